// File: rtl/mxint_arb_pkg.sv
// rtl/mxint_arb_pkg.sv - shared widths and round-robin helper for the caster arbiter
package mxint_arb_pkg;

  function automatic int tag_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Counter must hold the value MAX_OUTSTANDING itself, hence the extra bit.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

  function automatic int rr_next(input int idx, input int n_req);
    return (idx + 1 >= n_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mxint_cast_arbiter_if.sv
// rtl/mxint_cast_arbiter_if.sv - issue/response handshake bundle between arbiter and shared caster
interface mxint_cast_arbiter_if #(
  parameter int BLOCK_SIZE    = 4,
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 4,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 4
);
  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  cast_mdata_in;
  logic [IN_EXP_WIDTH-1:0]                  cast_edata_in;
  logic                                     cast_in_valid;
  logic                                     cast_in_ready;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] cast_mdata_out;
  logic [OUT_EXP_WIDTH-1:0]                 cast_edata_out;
  logic                                     cast_out_valid;
  logic                                     cast_out_ready;

  modport master (
    output cast_mdata_in, cast_edata_in, cast_in_valid, cast_out_ready,
    input  cast_in_ready, cast_mdata_out, cast_edata_out, cast_out_valid
  );

  modport slave (
    input  cast_mdata_in, cast_edata_in, cast_in_valid, cast_out_ready,
    output cast_in_ready, cast_mdata_out, cast_edata_out, cast_out_valid
  );
endinterface

// File: rtl/mxint_tag_fifo.sv
// rtl/mxint_tag_fifo.sv - circular buffer of requester tags for blocks in flight
module mxint_tag_fifo
  import mxint_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [cnt_width(DEPTH)-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mxint_cast_arbiter.sv
// rtl/mxint_cast_arbiter.sv - round-robin sharing of one mxint caster among N_REQ block streams
module mxint_cast_arbiter
  import mxint_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int IN_MAN_WIDTH    = 8,
  parameter int IN_EXP_WIDTH    = 4,
  parameter int OUT_MAN_WIDTH   = 8,
  parameter int OUT_EXP_WIDTH   = 4,
  parameter int BLOCK_SIZE      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [N_REQ-1:0]                                cfg_enable,
  input  logic [N_REQ-1:0][BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] req_mdata_in,
  input  logic [N_REQ-1:0][IN_EXP_WIDTH-1:0]              req_edata_in,
  input  logic [N_REQ-1:0]                                req_valid,
  output logic [N_REQ-1:0]                                req_ready,
  mxint_cast_arbiter_if.master                            cast,
  output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]        rsp_mdata_out,
  output logic [OUT_EXP_WIDTH-1:0]                        rsp_edata_out,
  output logic [N_REQ-1:0]                                rsp_valid,
  input  logic [N_REQ-1:0]                                rsp_ready,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]           outstanding,
  output logic                                            err_orphan
);
  localparam int TAG_W = tag_width(N_REQ);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [N_REQ-1:0] eligible;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] head;
  logic             grant_found;
  logic             full;
  logic             empty;
  logic             can_issue;
  logic             issue;
  logic             pop;

  assign eligible = req_valid & cfg_enable;

  // First eligible index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int               cand;
    logic [TAG_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = TAG_W'(cand);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant       = cand_idx;
      end
    end
  end

  assign full  = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign empty = (outstanding == '0);

  // Full blocks issue even when a pop retires a tag this same cycle.
  assign can_issue = rst & grant_found & ~full;
  assign issue     = can_issue & cast.cast_in_ready;

  assign cast.cast_in_valid = can_issue;
  assign cast.cast_mdata_in = req_mdata_in[grant];
  assign cast.cast_edata_in = req_edata_in[grant];

  always_comb begin
    req_ready        = '0;
    req_ready[grant] = issue;
  end

  always_comb begin
    rsp_valid       = '0;
    rsp_valid[head] = cast.cast_out_valid & ~empty;
  end

  assign cast.cast_out_ready = ~empty & rsp_ready[head];
  assign pop                 = cast.cast_out_valid & cast.cast_out_ready;
  assign rsp_mdata_out       = cast.cast_mdata_out;
  assign rsp_edata_out       = cast.cast_edata_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) rr_ptr <= TAG_W'(rr_next(int'(grant), N_REQ));
      if (cast.cast_out_valid && empty) err_orphan <= 1'b1;
    end
  end

  mxint_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (grant),
    .pop       (pop),
    .head      (head),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_mxint_cast_arbiter.sv
// tb/tb_mxint_cast_arbiter.sv - self-checking bench for mxint_cast_arbiter
module tb_mxint_cast_arbiter;
  localparam int N   = 4;
  localparam int BS  = 4;
  localparam int IMW = 8;
  localparam int IEW = 4;
  localparam int OMW = 8;
  localparam int OEW = 4;
  localparam int MO  = 4;

  typedef logic [BS-1:0][IMW-1:0] imant_t;
  typedef logic [BS-1:0][OMW-1:0] omant_t;
  typedef struct {
    int               id;
    imant_t           m;
    logic [IEW-1:0]   e;
  } blk_t;
  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] val;
    logic         cin;
    logic         civ;
    logic [N-1:0] rr;
    int           eg;
  } vec_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N-1:0]                 cfg_enable;
  logic [N-1:0][BS-1:0][IMW-1:0] req_mdata_in;
  logic [N-1:0][IEW-1:0]        req_edata_in;
  logic [N-1:0]                 req_valid;
  logic [N-1:0]                 req_ready;
  logic [BS-1:0][OMW-1:0]       rsp_mdata_out;
  logic [OEW-1:0]               rsp_edata_out;
  logic [N-1:0]                 rsp_valid;
  logic [N-1:0]                 rsp_ready;
  logic [2:0]                   outstanding;
  logic                         err_orphan;

  mxint_cast_arbiter_if #(
    .BLOCK_SIZE(BS), .IN_MAN_WIDTH(IMW), .IN_EXP_WIDTH(IEW),
    .OUT_MAN_WIDTH(OMW), .OUT_EXP_WIDTH(OEW)
  ) cif ();

  mxint_cast_arbiter #(
    .N_REQ(N), .IN_MAN_WIDTH(IMW), .IN_EXP_WIDTH(IEW), .OUT_MAN_WIDTH(OMW),
    .OUT_EXP_WIDTH(OEW), .BLOCK_SIZE(BS), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (cfg_enable),
    .req_mdata_in  (req_mdata_in),
    .req_edata_in  (req_edata_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .cast          (cif),
    .rsp_mdata_out (rsp_mdata_out),
    .rsp_edata_out (rsp_edata_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .outstanding   (outstanding),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  blk_t fl[$];
  int   ptr_m = 0;
  bit   out_en = 0;
  bit   orphan_force = 0;
  int   last_grant = -1;
  int   max_out = 0;
  int   n_pop = 0;
  int   gcount[N];
  int   delivered[N];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic omant_t xm(input imant_t m);
    omant_t r;
    for (int j = 0; j < BS; j++) r[j] = m[j] ^ 8'hA5;
    return r;
  endfunction

  // One clock: caster model drives outputs, reference checks DUT, then state advances.
  task automatic cycle();
    int           g;
    int           k;
    bit           exp_issue;
    bit           mdl_issue;
    bit           obs_issue;
    bit           obs_pop;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_rv;
    logic         exp_cor;
    if (fl.size() > 0) begin
      cif.cast_mdata_out = xm(fl[0].m);
      cif.cast_edata_out = fl[0].e ^ 4'h3;
    end else begin
      cif.cast_mdata_out = '0;
      cif.cast_edata_out = '0;
    end
    cif.cast_out_valid = orphan_force | (out_en & (fl.size() > 0));
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      k = (ptr_m + i) % N;
      if (g < 0 && req_valid[k] && cfg_enable[k]) g = k;
    end
    exp_issue = (g >= 0) && (fl.size() < MO);
    chk("cast_in_valid", cif.cast_in_valid, exp_issue);
    exp_rr = '0;
    if (exp_issue && cif.cast_in_ready) exp_rr[g] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    if (exp_issue) begin
      chk("cast_mdata_in", cif.cast_mdata_in, req_mdata_in[g]);
      chk("cast_edata_in", cif.cast_edata_in, req_edata_in[g]);
    end
    chk("outstanding", outstanding, fl.size());
    exp_rv  = '0;
    exp_cor = 1'b0;
    if (fl.size() > 0) begin
      exp_cor = rsp_ready[fl[0].id];
      if (cif.cast_out_valid) exp_rv[fl[0].id] = 1'b1;
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("cast_out_ready", cif.cast_out_ready, exp_cor);
    obs_issue = cif.cast_in_valid & cif.cast_in_ready;
    obs_pop   = cif.cast_out_valid & cif.cast_out_ready;
    if (obs_pop && fl.size() > 0) begin
      chk("rsp_mdata_out", rsp_mdata_out, xm(fl[0].m));
      chk("rsp_edata_out", rsp_edata_out, fl[0].e ^ 4'h3);
    end
    last_grant = -1;
    for (int i = 0; i < N; i++) begin
      if (obs_issue && req_ready[i]) last_grant = i;
      if (rsp_valid[i] && rsp_ready[i]) delivered[i]++;
    end
    if (last_grant >= 0) gcount[last_grant]++;
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    mdl_issue = exp_issue && cif.cast_in_ready;
    @(posedge clk);
    #1;
    if (obs_pop && fl.size() > 0) begin
      fl.delete(0);
      n_pop++;
    end
    if (mdl_issue) begin
      fl.push_back('{g, req_mdata_in[g], req_edata_in[g]});
      ptr_m = (g + 1) % N;
      req_mdata_in[g] = $urandom;
      req_edata_in[g] = 4'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    out_en = 1;
    orphan_force = 0;
    for (int i = 0; i < 20 && fl.size() > 0; i++) cycle();
    chk("drain_outstanding", outstanding, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fl.delete();
    ptr_m = 0;
    cif.cast_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int p0;
    int d0;
    int s2;
    int s3;
    rst = 1'b0;
    cfg_enable = '0;
    req_valid = '0;
    rsp_ready = '0;
    cif.cast_in_ready = 1'b0;
    cif.cast_out_valid = 1'b0;
    cif.cast_mdata_out = '0;
    cif.cast_edata_out = '0;
    for (int k = 0; k < N; k++) begin
      req_mdata_in[k] = $urandom;
      req_edata_in[k] = 4'(k + 1);
    end
    repeat (2) @(negedge clk);

    req_valid = '1;
    cfg_enable = '1;
    cif.cast_in_ready = 1'b1;
    #1;
    chk("reset_cast_in_valid", cif.cast_in_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_cast_out_ready", cif.cast_out_ready, 0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err_orphan", err_orphan, 0);
    req_valid = '0;
    cif.cast_in_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Combinational grant at rr_ptr = 0; no issue is ever committed here.
    tbl[0] = '{en:4'b1111, val:4'b0000, cin:1'b1, civ:1'b0, rr:4'b0000, eg:-1};
    tbl[1] = '{en:4'b1111, val:4'b1111, cin:1'b1, civ:1'b1, rr:4'b0001, eg:0};
    tbl[2] = '{en:4'b1111, val:4'b1100, cin:1'b1, civ:1'b1, rr:4'b0100, eg:2};
    tbl[3] = '{en:4'b1011, val:4'b0100, cin:1'b1, civ:1'b0, rr:4'b0000, eg:-1};
    tbl[4] = '{en:4'b1011, val:4'b1110, cin:1'b1, civ:1'b1, rr:4'b0010, eg:1};
    tbl[5] = '{en:4'b0000, val:4'b1111, cin:1'b1, civ:1'b0, rr:4'b0000, eg:-1};
    tbl[6] = '{en:4'b1111, val:4'b1000, cin:1'b0, civ:1'b1, rr:4'b0000, eg:3};
    tbl[7] = '{en:4'b0110, val:4'b1100, cin:1'b1, civ:1'b1, rr:4'b0100, eg:2};
    for (int i = 0; i < 8; i++) begin
      cfg_enable = tbl[i].en;
      req_valid = tbl[i].val;
      cif.cast_in_ready = tbl[i].cin;
      #1;
      chk("tbl_cast_in_valid", cif.cast_in_valid, tbl[i].civ);
      chk("tbl_req_ready", req_ready, tbl[i].rr);
      if (tbl[i].eg >= 0) chk("tbl_cast_edata_in", cif.cast_edata_in, tbl[i].eg + 1);
      cif.cast_in_ready = 1'b0;
      req_valid = '0;
      @(negedge clk);
    end

    // Round-robin with everything ready.
    cfg_enable = '1;
    req_valid = '1;
    cif.cast_in_ready = 1'b1;
    rsp_ready = '1;
    out_en = 1;
    max_out = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("rr_grant_seq", last_grant, i % N);
    end
    chk("rr_max_outstanding_le4", max_out <= MO, 1);
    drain();

    // Response stall: caster fills, then drains in order.
    req_valid = '1;
    rsp_ready = '0;
    cnt = 0;
    repeat (6) begin
      cycle();
      if (last_grant >= 0) cnt++;
    end
    chk("stall_issue_count", cnt, 4);
    chk("stall_cast_in_valid", cif.cast_in_valid, 0);
    chk("stall_outstanding", outstanding, 4);
    p0 = n_pop;
    drain();
    chk("stall_pop_count", n_pop - p0, 4);

    // Wrap-around from rr_ptr = 3.
    do_reset();
    cfg_enable = '1;
    rsp_ready = '1;
    cif.cast_in_ready = 1'b1;
    req_valid = 4'b0100;
    cycle();
    chk("wrap_first_grant", last_grant, 2);
    cycle();
    chk("wrap_second_grant", last_grant, 2);
    req_valid = 4'b0110;
    cycle();
    chk("wrap_third_grant", last_grant, 1);
    drain();

    // Masked requester never granted.
    cfg_enable = 4'b1011;
    req_valid = '1;
    s2 = gcount[2];
    s3 = gcount[3];
    repeat (40) begin
      cif.cast_in_ready = ($urandom % 4) != 0;
      rsp_ready = 4'($urandom) | 4'($urandom);
      out_en = ($urandom % 3) != 0;
      cycle();
    end
    chk("mask_req2_grants", gcount[2] - s2, 0);
    chk("mask_req3_granted", (gcount[3] - s3) > 0, 1);
    cif.cast_in_ready = 1'b1;
    drain();

    // Disable a requester while its block is in flight.
    cfg_enable = '1;
    rsp_ready = '0;
    req_valid = 4'b0001;
    cycle();
    chk("disable_issue_grant", last_grant, 0);
    req_valid = '0;
    cfg_enable = 4'b1110;
    d0 = delivered[0];
    drain();
    chk("disabled_delivery", delivered[0] - d0, 1);

    // Orphan response.
    cfg_enable = '1;
    chk("orphan_pre", err_orphan, 0);
    orphan_force = 1;
    cycle();
    chk("orphan_set", err_orphan, 1);
    orphan_force = 0;
    repeat (3) cycle();
    chk("orphan_sticky", err_orphan, 1);

    // Asynchronous reset with blocks in flight.
    req_valid = '1;
    rsp_ready = '0;
    out_en = 1;
    repeat (3) cycle();
    req_valid = '0;
    chk("prereset_outstanding", outstanding, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outstanding", outstanding, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    chk("async_reset_err_orphan", err_orphan, 0);
    chk("async_reset_cast_out_ready", cif.cast_out_ready, 0);
    fl.delete();
    ptr_m = 0;
    cif.cast_out_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = '1;
    req_valid = 4'b1100;
    cycle();
    chk("post_reset_grant", last_grant, 2);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cfg_enable = (($urandom % 8) == 0) ? 4'($urandom) : 4'b1111;
      req_valid = 4'($urandom);
      cif.cast_in_ready = ($urandom % 4) != 0;
      out_en = ($urandom % 3) != 0;
      rsp_ready = 4'($urandom) | 4'($urandom);
      cycle();
    end
    cif.cast_in_ready = 1'b1;
    drain();
    chk("random_no_orphan", err_orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mxint_cast_arbiter.md
Name: mxint_cast_arbiter

Overview:
- Shares one mxint_cast instance between N_REQ independent MxInt block streams.
- Arbitration is round-robin, one block per grant. Each issued block is tagged with its requester ID.
- Cast results are routed back to the originating requester in issue order.
- Sits between several layer producers and a single caster, so the caster does not need to be replicated per stream.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IN_MAN_WIDTH, 8, input mantissa width.
- IN_EXP_WIDTH, 4, input exponent width.
- OUT_MAN_WIDTH, 8, output mantissa width.
- OUT_EXP_WIDTH, 4, output exponent width.
- BLOCK_SIZE, 4, mantissas per block.
- MAX_OUTSTANDING, 4, maximum blocks in flight inside the caster (power of two, at least 2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_enable  in  [N_REQ]  per-requester grant enable.
- req_mdata_in  in  [N_REQ][BLOCK_SIZE] x IN_MAN_WIDTH  requester mantissas.
- req_edata_in  in  [N_REQ] x IN_EXP_WIDTH  requester exponents.
- req_valid  in  [N_REQ]  requester valid.
- req_ready  out  [N_REQ]  requester ready.
- cast_mdata_in  out  [BLOCK_SIZE] x IN_MAN_WIDTH  to caster.
- cast_edata_in  out  IN_EXP_WIDTH  to caster.
- cast_in_valid  out  1  to caster.
- cast_in_ready  in  1  from caster.
- cast_mdata_out  in  [BLOCK_SIZE] x OUT_MAN_WIDTH  from caster.
- cast_edata_out  in  OUT_EXP_WIDTH  from caster.
- cast_out_valid  in  1  from caster.
- cast_out_ready  out  1  to caster.
- rsp_mdata_out  out  [BLOCK_SIZE] x OUT_MAN_WIDTH  broadcast to all requesters.
- rsp_edata_out  out  OUT_EXP_WIDTH  broadcast to all requesters.
- rsp_valid  out  [N_REQ]  one-hot response valid.
- rsp_ready  in  [N_REQ]  per-requester response ready.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  blocks in flight.
- err_orphan  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - rr_ptr = 0, outstanding = 0, tag FIFO empty, err_orphan = 0.
  - Combinationally this gives cast_in_valid = 0, req_ready = 0, rsp_valid = 0, cast_out_ready = 0.
  - Reset mid-operation drops all in-flight tags. The caster must be reset by the same rst.
- Eligibility: eligible[k] = req_valid[k] & cfg_enable[k].
- Grant:
  - Combinational. Pick the first eligible index searching upward from rr_ptr, wrapping modulo N_REQ.
  - can_issue = any eligible AND outstanding < MAX_OUTSTANDING.
- Issue path:
  - cast_in_valid = can_issue.
  - cast_mdata_in and cast_edata_in come from the mux of the granted requester.
  - req_ready[g] = can_issue & cast_in_ready for granted g; all other req_ready bits are 0.
  - No latency is added on the issue path.
- Issue handshake (cast_in_valid & cast_in_ready):
  - Push tag g into the tag FIFO.
  - rr_ptr <= (g+1) mod N_REQ.
  - If no issue occurs, rr_ptr holds.
- Grant stability: the grant may change while the caster is stalled. Requesters follow valid/ready, so a requester whose valid is held keeps priority position.
- cfg_enable changes:
  - Take effect on the next grant evaluation.
  - Blocks already in flight for a now-disabled requester still return and are delivered.
- Response path:
  - head = tag FIFO head.
  - rsp_valid[head] = cast_out_valid & tag FIFO non-empty; all other rsp_valid bits are 0.
  - cast_out_ready = non-empty & rsp_ready[head].
  - rsp_mdata_out and rsp_edata_out equal cast_mdata_out and cast_edata_out (pass-through).
  - Pop the tag on cast_out_valid & cast_out_ready.
- Orphan response: cast_out_valid while the tag FIFO is empty sets err_orphan (sticky until reset). cast_out_ready stays 0.
- outstanding counter:
  - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - When full (outstanding == MAX_OUTSTANDING) no issue is allowed, even if a pop occurs the same cycle (no bypass).
- Ordering: responses return strictly in issue order. The caster is in-order.
- Head-of-line blocking on a stalled rsp_ready is intended behaviour.
- Width rules:
  - Tag width is $clog2(N_REQ).
  - Tag FIFO pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally.
  - Full and empty are derived from the outstanding counter.

Decomposition:
- Shared package mxint_arb_pkg holds:
  - TAG_W = $clog2(N_REQ) as a function of N_REQ.
  - The cnt_t width helper.
  - The round-robin next-index function.
- Sub-module mxint_tag_fifo: synchronous circular buffer of TAG_W-bit entries, depth MAX_OUTSTANDING, with push, pop, head, count and asynchronous active-low reset.
- The grant mux and response demux stay in the top module.

Test Plan:
- All 4 requesters hold valid, caster always ready, rsp_ready all 1 -> grants 0,1,2,3,0,... one per cycle. Each response block returns to its own rsp_valid bit with matching data. outstanding never exceeds 4.
- cast_in_ready = 1 while the caster output is stalled (cast_out_ready path blocked by rsp_ready = 0) for 6 cycles -> exactly 4 issues, then cast_in_valid = 0 with outstanding = 4. Releasing rsp_ready gives 4 in-order pops.
- Only requester 2 valid, ptr = 3 -> grant wraps to 2. After issue, ptr = 3. A following request on 1 and 2 together grants 1 first.
- cfg_enable = 4'b1011 with all valid -> requester 2 is never granted. Clearing enable[0] with a block from requester 0 in flight -> that block is still delivered on rsp_valid[0].
- Inject cast_out_valid = 1 with the FIFO empty -> err_orphan rises the next edge and stays 1. cast_out_ready = 0 throughout.
- Assert rst low with 3 blocks in flight -> outstanding = 0 and rsp_valid = 0 immediately, without waiting for a clock edge. After release, ptr = 0 and the first grant is the lowest eligible index.
